// File: rtl/utils_pkg.sv
// Shared state type and oversampling constants for the UART receive path.
package utils_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_st_t;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_SAMPLE_MID = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO; the head reads as zero while empty.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   pop,
    output logic [WIDTH-1:0]       data_out,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign data_out  = empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote, FWFT byte FIFO.
module uart_rx
    import utils_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        uart_rx_i,
    input  logic                        rx_en_i,
    input  logic [DIV_W-1:0]            baud_div_i,
    output logic [7:0]                  rx_data_o,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
    output logic                        frame_err_o,
    output logic                        overrun_err_o,
    input  logic                        err_clr_i,
    output logic                        rx_irq_o
);

    uart_rx_st_t      r_state;
    uart_rx_st_t      w_next;
    logic             r_sync1;
    logic             r_rx_s;
    logic             r_rx_prev;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_os_cnt;
    logic [2:0]       r_bit_cnt;
    logic [1:0]       r_samp;
    logic [7:0]       r_shift;
    logic             r_frame_err;
    logic             r_overrun_err;

    logic w_tick, w_eval, w_bit_end, w_maj;
    logic w_leave_idle, w_shift_en, w_push, w_frame_set;
    logic w_empty, w_full, w_overrun_set;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= uart_rx_i;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_tick    = (r_div_cnt == '0);
    assign w_eval    = w_tick && (r_os_cnt == 4'(UART_SAMPLE_MID + 1));
    assign w_bit_end = w_tick && (r_os_cnt == 4'(UART_OVERSAMPLE - 1));
    // Third vote is the live sample taken on the evaluation tick itself.
    assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s) | (r_samp[1] & r_rx_s);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_leave_idle = 1'b0;
        w_shift_en   = 1'b0;
        w_push       = 1'b0;
        w_frame_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_en_i && r_rx_prev && !r_rx_s) begin
                    w_next       = START;
                    w_leave_idle = 1'b1;
                end
            end
            START: begin
                if (w_eval && w_maj) begin
                    w_next = IDLE;
                end else if (w_bit_end) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                w_shift_en = w_eval;
                if (w_bit_end && (r_bit_cnt == 3'd7)) begin
                    w_next = STOP;
                end
            end
            STOP: begin
                if (w_eval) begin
                    w_next      = IDLE;
                    w_push      = w_maj;
                    w_frame_set = !w_maj;
                end
            end
            default: w_next = IDLE;
        endcase
        if (!rx_en_i) begin
            w_next       = IDLE;
            w_leave_idle = 1'b0;
            w_shift_en   = 1'b0;
            w_push       = 1'b0;
            w_frame_set  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_div_cnt <= '0;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_samp    <= '1;
            r_shift   <= '0;
        end else begin
            if (w_leave_idle) begin
                r_div_cnt <= baud_div_i;
                r_os_cnt  <= '0;
                r_bit_cnt <= '0;
            end else if (r_state != IDLE) begin
                if (w_tick) begin
                    r_div_cnt <= baud_div_i;
                    r_os_cnt  <= r_os_cnt + 1'b1;
                    if (r_os_cnt == 4'(UART_SAMPLE_MID - 1)) begin
                        r_samp[0] <= r_rx_s;
                    end
                    if (r_os_cnt == 4'(UART_SAMPLE_MID)) begin
                        r_samp[1] <= r_rx_s;
                    end
                    if (w_bit_end && (r_state == DATA)) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end else begin
                    r_div_cnt <= r_div_cnt - 1'b1;
                end
            end
            if (w_shift_en) begin
                r_shift <= {w_maj, r_shift[7:1]};
            end
        end
    end

    assign w_overrun_set = w_push && w_full && !rx_ready_i;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= w_frame_set   ? 1'b1 : (err_clr_i ? 1'b0 : r_frame_err);
            r_overrun_err <= w_overrun_set ? 1'b1 : (err_clr_i ? 1'b0 : r_overrun_err);
        end
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arst     (arst),
        .push     (w_push),
        .data_in  (r_shift),
        .pop      (rx_ready_i),
        .data_out (rx_data_o),
        .empty    (w_empty),
        .full     (w_full),
        .count    (fifo_cnt_o)
    );

    assign rx_valid_o    = !w_empty;
    assign rx_irq_o      = !w_empty;
    assign frame_err_o   = r_frame_err;
    assign overrun_err_o = r_overrun_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written multi-frame sequences.
module tb_uart_rx;

    localparam int unsigned BIT_CLK = 64;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_rx;
        logic       exp_ferr;
    } vec_t;

    logic        clk = 1'b0;
    logic        arst;
    logic        uart_rx_i;
    logic        rx_en_i;
    logic [15:0] baud_div_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic [4:0]  fifo_cnt_o;
    logic        frame_err_o;
    logic        overrun_err_o;
    logic        err_clr_i;
    logic        rx_irq_o;

    int         n_vec = 0;
    int         n_err = 0;
    int         vcycles = 0;
    logic [7:0] rxq[$];
    vec_t       tbl[6];

    uart_rx #(
        .FIFO_DEPTH (16),
        .DIV_W      (16)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .uart_rx_i     (uart_rx_i),
        .rx_en_i       (rx_en_i),
        .baud_div_i    (baud_div_i),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .rx_ready_i    (rx_ready_i),
        .fifo_cnt_o    (fifo_cnt_o),
        .frame_err_o   (frame_err_o),
        .overrun_err_o (overrun_err_o),
        .err_clr_i     (err_clr_i),
        .rx_irq_o      (rx_irq_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (arst && rx_valid_o) begin
            vcycles++;
            if (rx_ready_i) rxq.push_back(rx_data_o);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] qat(input int i);
        return (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        uart_rx_i = b;
        cycles(BIT_CLK);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        uart_rx_i = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},    32'(rx_data_o),     0);
        check({tag, "_valid"},   32'(rx_valid_o),    0);
        check({tag, "_cnt"},     32'(fifo_cnt_o),    0);
        check({tag, "_ferr"},    32'(frame_err_o),   0);
        check({tag, "_overrun"}, 32'(overrun_err_o), 0);
        check({tag, "_irq"},     32'(rx_irq_o),      0);
    endtask

    initial begin
        int v0;
        logic [7:0] b96;

        tbl[0] = '{data: 8'hA5, stop: 1'b1, exp_rx: 1, exp_ferr: 1'b0};
        tbl[1] = '{data: 8'h55, stop: 1'b0, exp_rx: 0, exp_ferr: 1'b1};
        tbl[2] = '{data: 8'h00, stop: 1'b1, exp_rx: 1, exp_ferr: 1'b0};
        tbl[3] = '{data: 8'hFF, stop: 1'b1, exp_rx: 1, exp_ferr: 1'b0};
        tbl[4] = '{data: 8'h01, stop: 1'b1, exp_rx: 1, exp_ferr: 1'b0};
        tbl[5] = '{data: 8'h80, stop: 1'b1, exp_rx: 1, exp_ferr: 1'b0};

        arst       = 1'b0;
        uart_rx_i  = 1'b1;
        rx_en_i    = 1'b1;
        baud_div_i = 16'd3;
        rx_ready_i = 1'b1;
        err_clr_i  = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        cycles(3);
        arst = 1'b1;
        cycles(10);

        foreach (tbl[i]) begin
            rxq.delete();
            v0 = vcycles;
            send_byte(tbl[i].data, tbl[i].stop);
            cycles(20);
            @(negedge clk);
            check("tbl_rx_count", 32'(rxq.size()), 32'(tbl[i].exp_rx));
            check("tbl_valid_cycles", 32'(vcycles - v0), 32'(tbl[i].exp_rx));
            if (tbl[i].exp_rx == 1) check("tbl_data", qat(0), 32'(tbl[i].data));
            check("tbl_frame_err", 32'(frame_err_o), 32'(tbl[i].exp_ferr));
            check("tbl_overrun", 32'(overrun_err_o), 0);
            check("tbl_fifo_cnt", 32'(fifo_cnt_o), 0);
            @(posedge clk); #1;
            err_clr_i = 1'b1;
            cycles(1);
            err_clr_i = 1'b0;
            @(negedge clk);
            check("tbl_ferr_cleared", 32'(frame_err_o), 0);
            cycles(5);
        end

        // false start: 12 clk low pulse, shorter than half a bit
        rxq.delete();
        uart_rx_i = 1'b0;
        cycles(12);
        uart_rx_i = 1'b1;
        cycles(100);
        @(negedge clk);
        check("false_start_no_push", 32'(rxq.size()), 0);
        check("false_start_cnt", 32'(fifo_cnt_o), 0);
        check("false_start_ferr", 32'(frame_err_o), 0);
        @(posedge clk); #1;
        send_byte(8'h3C, 1'b1);
        cycles(20);
        @(negedge clk);
        check("after_false_count", 32'(rxq.size()), 1);
        check("after_false_data", qat(0), 32'h3C);

        // back-to-back frames, no idle gap
        rxq.delete();
        @(posedge clk); #1;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h81, 1'b1);
        cycles(20);
        @(negedge clk);
        check("b2b_count", 32'(rxq.size()), 3);
        check("b2b_data0", qat(0), 32'h00);
        check("b2b_data1", qat(1), 32'hFF);
        check("b2b_data2", qat(2), 32'h81);
        check("b2b_ferr", 32'(frame_err_o), 0);
        check("b2b_overrun", 32'(overrun_err_o), 0);

        // overrun: 17 bytes into a 16-deep FIFO with no consumer
        rxq.delete();
        @(posedge clk); #1;
        rx_ready_i = 1'b0;
        for (int b = 0; b < 17; b++) send_byte(8'(b), 1'b1);
        cycles(20);
        @(negedge clk);
        check("ovr_cnt", 32'(fifo_cnt_o), 16);
        check("ovr_flag", 32'(overrun_err_o), 1);
        check("ovr_valid", 32'(rx_valid_o), 1);
        check("ovr_irq", 32'(rx_irq_o), 1);
        check("ovr_head", 32'(rx_data_o), 32'h00);
        check("ovr_no_pop", 32'(rxq.size()), 0);
        @(posedge clk); #1;
        rx_ready_i = 1'b1;
        cycles(30);
        @(negedge clk);
        check("drain_count", 32'(rxq.size()), 16);
        for (int i = 0; i < 16; i++) check("drain_data", qat(i), 32'(i));
        check("drain_cnt", 32'(fifo_cnt_o), 0);
        check("drain_valid", 32'(rx_valid_o), 0);
        check("drain_overrun_sticky", 32'(overrun_err_o), 1);

        // leave one byte queued so reset has FIFO state to clear
        @(posedge clk); #1;
        rx_ready_i = 1'b0;
        send_byte(8'h42, 1'b1);
        cycles(20);
        @(negedge clk);
        check("pre_rst_cnt", 32'(fifo_cnt_o), 1);
        check("pre_rst_data", 32'(rx_data_o), 32'h42);

        // reset in the middle of bit 3 of 0x96
        @(posedge clk); #1;
        b96 = 8'h96;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b96[i]);
        uart_rx_i = b96[3];
        cycles(32);
        arst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;
        uart_rx_i = 1'b1;
        cycles(5);
        arst = 1'b1;
        cycles(200);
        rx_ready_i = 1'b1;
        rxq.delete();
        send_byte(8'h69, 1'b1);
        cycles(20);
        @(negedge clk);
        check("post_rst_count", 32'(rxq.size()), 1);
        check("post_rst_data", qat(0), 32'h69);
        check("post_rst_ferr", 32'(frame_err_o), 0);
        check("post_rst_overrun", 32'(overrun_err_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, 8N1, 16x oversampled, majority-vote bit sampling, with a byte FIFO and a valid/ready output stream. It is the receive half of the SoC UART and drives the currently unused uart_rx_i path. The bus-facing register wrapper pops bytes from it and exposes status and interrupt.

Parameters:
FIFO_DEPTH, 16, RX byte FIFO entries; power of two, >= 2
DIV_W, 16, width of the baud divider input

Ports:
clk  in  1  core clock
arst  in  1  asynchronous reset, active-low
uart_rx_i  in  1  serial line, asynchronous to clk, idle high
rx_en_i  in  1  receiver enable
baud_div_i  in  DIV_W  oversample tick period minus 1 = clk/(16*baud) - 1
rx_data_o  out  8  FIFO head byte (first-word fall-through)
rx_valid_o  out  1  FIFO not empty
rx_ready_i  in  1  pop FIFO head when rx_valid_o is also high
fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
frame_err_o  out  1  sticky: a stop bit was sampled as 0
overrun_err_o  out  1  sticky: a byte was dropped because the FIFO was full
err_clr_i  in  1  clears both sticky error flags
rx_irq_o  out  1  equals rx_valid_o

Behaviour:
- Reset (arst=0, takes effect asynchronously):
  - all outputs 0; FIFO empty; FSM in IDLE.
  - synchroniser flops and rx_prev reset to 1.
- Input synchroniser:
  - uart_rx_i passes through 2 flops to give rx_s; rx_prev is rx_s delayed by one cycle.
  - A pin edge therefore reaches rx_s 2 cycles later.
- Tick generator:
  - down-counter loaded with baud_div_i; tick is asserted for 1 cycle when the count is 0, then the counter reloads.
  - The counter reloads from baud_div_i when leaving IDLE, so the bit phase is aligned to the start edge.
  - A change to baud_div_i takes effect at the next reload; changing it mid-frame is unsupported.
- Oversample counter os_cnt:
  - 4-bit, increments on each tick; cleared when leaving IDLE.
  - Samples are taken on the ticks at os_cnt 7, 8 and 9.
  - maj = majority of the 3 samples, evaluated on the os_cnt==9 tick.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if rx_en_i && rx_prev==1 && rx_s==0, go to START.
  - START: on the maj evaluation, maj==1 is a false start and returns to IDLE; maj==0 continues. START moves to DATA on the os_cnt==15 tick.
  - DATA: at each maj evaluation, shift maj into the shift register LSB-first. Bit counter 0..7; after bit 7 completes (os_cnt==15 tick), go to STOP.
  - STOP: on the maj evaluation, go to IDLE immediately, half a bit early, to allow resync.
    - maj==1: push the byte.
    - maj==0: set frame_err_o and discard the byte.
  - rx_en_i=0 forces IDLE in any state. A frame in progress is discarded with no error flag. FIFO contents are retained.
- FIFO:
  - push and pop share one clock.
  - A push is accepted if !full, or if full and a pop happens in the same cycle.
  - Otherwise overrun_err_o is set and the new byte is dropped; the stored bytes are unchanged.
  - A pop when empty is ignored. Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; the count distinguishes full from empty.
- Latency: a pushed byte is visible on rx_data_o with rx_valid_o=1 in the cycle after the STOP maj-evaluation cycle.
- Sticky flags: err_clr_i clears both flags. If a set event and err_clr_i occur in the same cycle, the set wins.
- Reset mid-frame: the frame is lost and everything returns to reset values. The next complete frame after reset release is received normally.

Decomposition:
- Shared package utils_pkg:
  - typedef enum uart_rx_st_t {IDLE, START, DATA, STOP}
  - localparam UART_OVERSAMPLE = 16
  - localparam UART_SAMPLE_MID = 8
- One sub-module, uart_rx_fifo:
  - parameterised synchronous FWFT FIFO (WIDTH, DEPTH)
  - ports: push/data_in, pop, data_out, empty, full, count
  - same clock and reset as uart_rx.

Test Plan:
- baud_div_i=3 (tick every 4 clk, 1 bit = 64 clk), rx_en_i=1, ready=1, send 0xA5 -> rx_data_o=0xA5, rx_valid_o for exactly 1 cycle; no error flags; fifo_cnt_o returns to 0.
- Line low for 12 clk (less than half a bit), then high -> false start, no push, FSM back in IDLE, next frame 0x3C received correctly.
- Send 0x55 with stop bit driven 0 -> frame_err_o=1, fifo_cnt_o=0; assert err_clr_i -> frame_err_o=0 next cycle.
- ready=0, send 17 bytes 0x00..0x10 back-to-back (FIFO_DEPTH=16):
  - fifo_cnt_o=16 and overrun_err_o=1
  - draining yields 0x00..0x0F in order.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> all three received in order, no errors.
- Assert arst mid-DATA of 0x96 -> all outputs 0 during reset; after release, 0x69 is received correctly and 0x96 is never output.
